fir_psum_accum: RTL and testbench

- Downstream stage of the transposed-FIR PE row.
- Consumes the registered FIR output stream and discards the pipeline-fill samples at the start of each row pass.
- Accumulates the valid outputs across several input-channel passes into a local partial-sum buffer, then drains the finished row through a valid/ready handshake to the PE output collector.

---
 rtl/fir_psum_accum.sv | 207 ++++++++++++++++++++
 tb/tb_fir_psum_accum.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_psum_accum.sv
// Partial-sum accumulator behind the transposed-FIR PE row: drops pipeline fill,
// accumulates several channel passes per row, then drains the row over valid/ready.
module fir_psum_accum #(
    parameter int unsigned nb_taps     = 5,
    parameter int unsigned DReg_width  = 24,
    parameter int unsigned ACC_width   = 32,
    parameter int unsigned max_row_len = 16,
    parameter int unsigned cnt_width   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DReg_width-1:0] fir_out,
    input  logic                  fir_valid,
    input  logic                  row_start,
    input  logic [7:0]            nb_pass,
    input  logic [cnt_width-1:0]  row_outputs,
    output logic [ACC_width-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  sat_flag,
    output logic                  proto_err
);

    localparam int unsigned idx_w  = (max_row_len > 1) ? $clog2(max_row_len) : 1;
    localparam int unsigned skip_w = (nb_taps > 2) ? $clog2(nb_taps - 1) : 1;
    localparam int unsigned sum_w  = ACC_width + 1;

    localparam logic [skip_w-1:0] skip_last = skip_w'((nb_taps > 1) ? nb_taps - 2 : 0);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SKIP  = 3'd1;
    localparam logic [2:0] ACC   = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    // With a single tap there is no fill to discard.
    localparam logic [2:0] pass_entry = (nb_taps == 1) ? ACC : SKIP;

    logic [2:0]            state, state_nxt;
    logic [skip_w-1:0]     skip_cnt, skip_cnt_nxt;
    logic [cnt_width-1:0]  idx, idx_nxt;
    logic [cnt_width-1:0]  rd_idx, rd_idx_nxt;
    logic [7:0]            pass_cnt, pass_cnt_nxt;
    logic [7:0]            nb_pass_r, nb_pass_r_nxt;
    logic [cnt_width-1:0]  row_len_r, row_len_r_nxt;
    logic [ACC_width-1:0]  out_data_nxt;
    logic                  out_valid_nxt, done_nxt, sat_flag_nxt, proto_err_nxt, busy_nxt;

    logic [ACC_width-1:0]  psum_mem [max_row_len];
    logic                  mem_we;
    logic [idx_w-1:0]      mem_wa;
    logic [ACC_width-1:0]  mem_wd;

    logic [sum_w-1:0]      sample_ext, acc_ext, sum;
    logic [ACC_width-1:0]  acc_rd, sat_val;
    logic                  sum_ovf;
    logic [idx_w-1:0]      rd_addr;
    logic [7:0]            nb_pass_eff;
    logic [cnt_width-1:0]  row_len_eff;

    // Saturating add evaluated one bit wider than the accumulator.
    assign sample_ext = {{(sum_w - DReg_width){fir_out[DReg_width-1]}}, fir_out};
    assign acc_rd     = psum_mem[idx[idx_w-1:0]];
    assign acc_ext    = {acc_rd[ACC_width-1], acc_rd};
    assign sum        = acc_ext + sample_ext;
    assign sum_ovf    = sum[sum_w-1] ^ sum[sum_w-2];
    assign sat_val    = sum[sum_w-1] ? {1'b1, {(ACC_width-1){1'b0}}}
                                     : {1'b0, {(ACC_width-1){1'b1}}};
    assign rd_addr    = rd_idx[idx_w-1:0] + idx_w'(1);

    assign nb_pass_eff = (nb_pass == 8'd0) ? 8'd1 : nb_pass;
    assign row_len_eff = (row_outputs == '0) ? cnt_width'(1) :
                         (row_outputs > cnt_width'(max_row_len)) ? cnt_width'(max_row_len) :
                         row_outputs;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            idx       <= '0;
            rd_idx    <= '0;
            pass_cnt  <= '0;
            nb_pass_r <= '0;
            row_len_r <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
            proto_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            skip_cnt  <= skip_cnt_nxt;
            idx       <= idx_nxt;
            rd_idx    <= rd_idx_nxt;
            pass_cnt  <= pass_cnt_nxt;
            nb_pass_r <= nb_pass_r_nxt;
            row_len_r <= row_len_r_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            done      <= done_nxt;
            sat_flag  <= sat_flag_nxt;
            proto_err <= proto_err_nxt;
            busy      <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) psum_mem[mem_wa] <= mem_wd;
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_nxt     = state;
        skip_cnt_nxt  = skip_cnt;
        idx_nxt       = idx;
        rd_idx_nxt    = rd_idx;
        pass_cnt_nxt  = pass_cnt;
        nb_pass_r_nxt = nb_pass_r;
        row_len_r_nxt = row_len_r;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        done_nxt      = 1'b0;
        sat_flag_nxt  = sat_flag;
        proto_err_nxt = proto_err;
        mem_we        = 1'b0;
        mem_wa        = idx[idx_w-1:0];
        mem_wd        = sample_ext[ACC_width-1:0];

        case (state)
            IDLE: begin
                if (row_start) begin
                    nb_pass_r_nxt = nb_pass_eff;
                    row_len_r_nxt = row_len_eff;
                    pass_cnt_nxt  = '0;
                    skip_cnt_nxt  = '0;
                    idx_nxt       = '0;
                    sat_flag_nxt  = 1'b0;
                    proto_err_nxt = fir_valid;
                    state_nxt     = pass_entry;
                end else if (fir_valid) begin
                    proto_err_nxt = 1'b1;
                end
            end
            SKIP: begin
                if (row_start) proto_err_nxt = 1'b1;
                if (fir_valid) begin
                    if (skip_cnt == skip_last) begin
                        skip_cnt_nxt = '0;
                        state_nxt    = ACC;
                    end else begin
                        skip_cnt_nxt = skip_cnt + skip_w'(1);
                    end
                end
            end
            ACC: begin
                if (row_start) proto_err_nxt = 1'b1;
                if (fir_valid) begin
                    mem_we = 1'b1;
                    if (pass_cnt != 8'd0) begin
                        mem_wd = sum_ovf ? sat_val : sum[ACC_width-1:0];
                        if (sum_ovf) sat_flag_nxt = 1'b1;
                    end
                    if (idx == row_len_r - cnt_width'(1)) begin
                        idx_nxt      = '0;
                        pass_cnt_nxt = pass_cnt + 8'd1;
                        rd_idx_nxt   = '0;
                        state_nxt    = (pass_cnt + 8'd1 == nb_pass_r) ? DRAIN : WAIT;
                    end else begin
                        idx_nxt = idx + cnt_width'(1);
                    end
                end
            end
            WAIT: begin
                if (fir_valid) proto_err_nxt = 1'b1;
                if (row_start) begin
                    skip_cnt_nxt = '0;
                    state_nxt    = pass_entry;
                end
            end
            DRAIN: begin
                if (fir_valid || row_start) proto_err_nxt = 1'b1;
                if (!out_valid) begin
                    out_data_nxt  = psum_mem[0];
                    out_valid_nxt = 1'b1;
                end else if (out_ready) begin
                    if (rd_idx == row_len_r - cnt_width'(1)) begin
                        out_valid_nxt = 1'b0;
                        done_nxt      = 1'b1;
                        rd_idx_nxt    = '0;
                        state_nxt     = IDLE;
                    end else begin
                        rd_idx_nxt   = rd_idx + cnt_width'(1);
                        out_data_nxt = psum_mem[rd_addr];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_fir_psum_accum.sv
// Directed bench for fir_psum_accum: a 32-bit and a 25-bit accumulator share one stimulus stream.
module tb_fir_psum_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] fir_out;
    logic        fir_valid, row_start, out_ready;
    logic [7:0]  nb_pass;
    logic [4:0]  row_outputs;

    logic [31:0] o32;
    logic        v32, busy32, done32, sat32, perr32;
    logic [24:0] o25;
    logic        v25, busy25, done25, sat25, perr25;

    int n_tests = 0;
    int n_fail  = 0;
    longint exp32 [4];
    longint exp25 [4];

    always #5 clk = ~clk;

    fir_psum_accum dut32 (
        .clk(clk), .rst_n(rst_n), .fir_out(fir_out), .fir_valid(fir_valid),
        .row_start(row_start), .nb_pass(nb_pass), .row_outputs(row_outputs),
        .out_data(o32), .out_valid(v32), .out_ready(out_ready), .busy(busy32),
        .done(done32), .sat_flag(sat32), .proto_err(perr32)
    );

    fir_psum_accum #(.ACC_width(25)) dut25 (
        .clk(clk), .rst_n(rst_n), .fir_out(fir_out), .fir_valid(fir_valid),
        .row_start(row_start), .nb_pass(nb_pass), .row_outputs(row_outputs),
        .out_data(o25), .out_valid(v25), .out_ready(out_ready), .busy(busy25),
        .done(done25), .sat_flag(sat25), .proto_err(perr25)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s);
        fir_valid = 1'b1;
        fir_out   = 24'(s);
        tick();
        fir_valid = 1'b0;
    endtask

    task automatic fill(input int s);
        repeat (4) send(s);
    endtask

    task automatic start(input int np, input int ro);
        row_start   = 1'b1;
        nb_pass     = 8'(np);
        row_outputs = 5'(ro);
        tick();
        row_start = 1'b0;
    endtask

    // Drains n results against exp32/exp25; stalls out_ready for 3 cycles before element `stall`.
    task automatic drain(input string tag, input int n, input int stall);
        int w;
        w = 0;
        out_ready = 1'b1;
        while (!v32 && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_latency"}, longint'(w), 1);
        for (int i = 0; i < n; i++) begin
            if (i == stall) begin
                out_ready = 1'b0;
                repeat (3) begin
                    tick();
                    check({tag, "_hold_valid"}, longint'(v32), 1);
                    check({tag, "_hold_data"}, longint'($signed(o32)), exp32[i]);
                end
                out_ready = 1'b1;
            end
            check({tag, "_valid"}, longint'(v32), 1);
            check({tag, "_data32"}, longint'($signed(o32)), exp32[i]);
            check({tag, "_data25"}, longint'($signed(o25)), exp25[i]);
            tick();
        end
        check({tag, "_done"}, longint'(done32), 1);
        check({tag, "_valid_low"}, longint'(v32), 0);
        tick();
        check({tag, "_done_pulse"}, longint'(done32), 0);
        check({tag, "_idle"}, longint'(busy32), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; fir_out = '0; fir_valid = 1'b0; row_start = 1'b0;
        nb_pass = '0; row_outputs = '0; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_out_data", longint'(o32), 0);
        check("rst_out_valid", longint'(v32), 0);
        check("rst_busy", longint'(busy32), 0);
        check("rst_done", longint'(done32), 0);
        check("rst_sat", longint'(sat32), 0);
        check("rst_proto", longint'(perr32), 0);
        rst_n = 1'b1;
        tick();

        // Basic two-pass row: (1,2,3) + (100,200,300).
        start(2, 3);
        check("basic_busy", longint'(busy32), 1);
        send(10); send(20); send(30); send(40);
        send(1); send(2); send(3);
        check("basic_wait_busy", longint'(busy32), 1);
        start(2, 3);
        fill(9);
        send(100); send(200); send(300);
        exp32 = '{101, 202, 303, 0};
        exp25 = '{101, 202, 303, 0};
        drain("basic", 3, -1);
        check("basic_sat", longint'(sat32), 0);
        check("basic_proto", longint'(perr32), 0);

        // Sign extension of 0xFFFFFF.
        start(1, 1);
        fill(0);
        send(24'hFFFFFF);
        exp32 = '{-1, 0, 0, 0};
        exp25 = '{-1, 0, 0, 0};
        drain("sext", 1, -1);

        // Positive saturation over three passes.
        for (int p = 0; p < 3; p++) begin
            start(3, 1);
            fill(0);
            send(8388607);
        end
        exp32 = '{25165821, 0, 0, 0};
        exp25 = '{16777215, 0, 0, 0};
        drain("satpos", 1, -1);
        check("satpos_flag25", longint'(sat25), 1);
        check("satpos_flag32", longint'(sat32), 0);

        // Negative saturation; flag must clear at row start first.
        start(3, 1);
        check("satneg_clear", longint'(sat25), 0);
        fill(0);
        send(-8388608);
        for (int p = 1; p < 3; p++) begin
            start(3, 1);
            fill(0);
            send(-8388608);
        end
        exp32 = '{-25165824, 0, 0, 0};
        exp25 = '{-16777216, 0, 0, 0};
        drain("satneg", 1, -1);
        check("satneg_flag25", longint'(sat25), 1);

        // Backpressure on the second element.
        start(1, 4);
        fill(0);
        send(5); send(6); send(7); send(8);
        exp32 = '{5, 6, 7, 8};
        exp25 = '{5, 6, 7, 8};
        drain("bp", 4, 1);

        // Stray sample in WAIT must not disturb the buffer.
        start(2, 2);
        fill(0);
        send(7); send(8);
        send(1000);
        check("wait_proto", longint'(perr32), 1);
        start(2, 2);
        fill(0);
        send(1); send(1);
        exp32 = '{8, 9, 0, 0};
        exp25 = '{8, 9, 0, 0};
        drain("waitv", 2, -1);
        check("wait_proto_sticky", longint'(perr32), 1);

        // row_start during ACC is ignored.
        start(1, 3);
        check("acc_proto_clear", longint'(perr32), 0);
        fill(0);
        send(1);
        row_start = 1'b1;
        tick();
        row_start = 1'b0;
        check("acc_proto", longint'(perr32), 1);
        send(2); send(3);
        exp32 = '{1, 2, 3, 0};
        exp25 = '{1, 2, 3, 0};
        drain("accrs", 3, -1);

        // Reset one edge after the first result is accepted.
        start(1, 3);
        fill(0);
        send(4); send(5); send(6);
        out_ready = 1'b1;
        tick();
        check("rstd_first_valid", longint'(v32), 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstd_valid", longint'(v32), 0);
        check("rstd_busy", longint'(busy32), 0);
        check("rstd_done", longint'(done32), 0);
        start(1, 2);
        fill(0);
        send(11); send(12);
        exp32 = '{11, 12, 0, 0};
        exp25 = '{11, 12, 0, 0};
        drain("rstd_new", 2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
